// File: rtl/mem_access_unit.sv
// Unified instruction/data memory access stage for the multicycle RISC-V core.
// Turns controller strobes into one handshaked bus transaction and stalls the FSM meanwhile.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IR_Write,
  input  logic        AdrSrc,
  input  logic        Mem_Write,
  input  logic [31:0] PC,
  input  logic [31:0] Result,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] Instr,
  output logic [31:0] OldPC,
  output logic [31:0] Data,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r;
  state_t      state_s;
  kind_t       kind_r;
  kind_t       kind_s;
  logic [31:0] pc_r;
  logic [7:0]  cnt_r;
  logic [31:0] addr_s;
  logic        acc_s;
  logic        ready_hit_s;
  logic        timeout_s;

  assign acc_s = IR_Write | AdrSrc;

  // Decode request kind and word-aligned address; fetch wins over a data access.
  always_comb begin
    kind_s = K_LOAD;
    addr_s = Result & 32'hFFFF_FFFC;
    if (IR_Write) begin
      kind_s = K_FETCH;
      addr_s = PC & 32'hFFFF_FFFC;
    end else if (Mem_Write) begin
      kind_s = K_STORE;
    end else begin
      kind_s = K_LOAD;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, stall and completion qualifiers; DONE ignores acc to block re-issue.
  always_comb begin
    state_s     = state_r;
    Stall       = 1'b0;
    ready_hit_s = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        Stall = acc_s;
        if (acc_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (mem_ready) begin
          ready_hit_s = 1'b1;
          state_s     = DONE;
        end else if (cnt_r <= 8'd1) begin
          timeout_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = REQ;
        end
      end
      DONE: begin
        Stall   = 1'b0;
        state_s = IDLE;
      end
      default: begin
        Stall   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Bus drive, wait counter and capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_r    <= K_FETCH;
      pc_r      <= 32'd0;
      cnt_r     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      Instr     <= 32'd0;
      OldPC     <= 32'd0;
      Data      <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            kind_r    <= kind_s;
            pc_r      <= PC;
            cnt_r     <= TIMEOUT_C;
            mem_req   <= 1'b1;
            mem_we    <= (kind_s == K_STORE);
            mem_addr  <= addr_s;
            mem_wdata <= WriteData;
          end
        end
        REQ: begin
          if (ready_hit_s) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (kind_r)
              K_FETCH: begin
                Instr <= mem_rdata;
                OldPC <= pc_r;
              end
              K_LOAD:  Data <= mem_rdata;
              default: ;
            endcase
          end else if (timeout_s) begin
            // Abandoned fetch executes as a NOP; abandoned load returns zero.
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            case (kind_r)
              K_FETCH: begin
                Instr <= NOP_INSTR;
                OldPC <= pc_r;
              end
              K_LOAD:  Data <= 32'd0;
              default: ;
            endcase
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
